// File: rtl/op_handler_scheduler_if.sv
// Opcode record type and the valid/rdy channel that carries parsed ops
// from the op source into the handler scheduler.
package op_handler_pkg;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] feed;
    } op_st;

    localparam logic [7:0] CMD_G00 = 8'd0;
    localparam logic [7:0] CMD_G01 = 8'd1;
    localparam logic [7:0] CMD_G02 = 8'd2;
    localparam logic [7:0] CMD_G03 = 8'd3;
    localparam logic [7:0] CMD_G90 = 8'd90;
    localparam logic [7:0] CMD_G91 = 8'd91;

endpackage

interface op_handler_scheduler_if;
    import op_handler_pkg::*;

    op_st op_in;
    logic op_valid;
    logic op_rdy;

    modport master (output op_in, output op_valid, input op_rdy);
    modport slave  (input op_in, input op_valid, output op_rdy);

endinterface

// File: rtl/op_handler_scheduler.sv
// Latches one op at a time, triggers the handler chosen by its cmd and waits
// for that handler's done, with a watchdog and a completed-op counter.
//
// state     | meaning
// IDLE      | op_rdy high, waiting for op_valid
// WAIT_RDY  | op latched, waiting for the selected handler's rdy
// TRIGGER   | selected trigger high for this single cycle
// WAIT_DONE | waiting for selected done, watchdog running
module op_handler_scheduler
    import op_handler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    op_handler_scheduler_if.slave     op_bus,
    output op_st                      cur_op,
    output logic                      lin_trigger,
    input  logic                      lin_rdy,
    input  logic                      lin_done,
    output logic                      circ_trigger,
    input  logic                      circ_rdy,
    input  logic                      circ_done,
    output logic                      dummy_trigger,
    input  logic                      dummy_rdy,
    input  logic                      dummy_done,
    input  logic                      clear_err,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [CNT_WIDTH-1:0]      ops_done_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, TRIGGER, WAIT_DONE} state_t;
    typedef enum logic [1:0] {SEL_LIN, SEL_CIRC, SEL_DUMMY} sel_t;

    state_t          state;
    sel_t            sel;
    logic            sel_rdy;
    logic            sel_done;
    logic            wd_expired;
    logic            timeout_set;
    logic            op_rdy_q;
    logic [WD_W-1:0] wd_cnt;

    assign op_bus.op_rdy = op_rdy_q;

    // Routing looks only at the latched op so op_in may change freely after accept.
    always_comb begin
        sel = SEL_DUMMY;
        case (cur_op.cmd)
            CMD_G00, CMD_G01: sel = SEL_LIN;
            CMD_G02, CMD_G03: sel = SEL_CIRC;
            default:          sel = SEL_DUMMY;
        endcase
        sel_rdy  = 1'b0;
        sel_done = 1'b0;
        case (sel)
            SEL_LIN: begin
                sel_rdy  = lin_rdy;
                sel_done = lin_done;
            end
            SEL_CIRC: begin
                sel_rdy  = circ_rdy;
                sel_done = circ_done;
            end
            default: begin
                sel_rdy  = dummy_rdy;
                sel_done = dummy_done;
            end
        endcase
    end

    assign wd_expired  = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
    assign timeout_set = (state == WAIT_DONE) && !sel_done && wd_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_rdy_q       <= 1'b1;
            busy           <= 1'b0;
            lin_trigger    <= 1'b0;
            circ_trigger   <= 1'b0;
            dummy_trigger  <= 1'b0;
            timeout_err    <= 1'b0;
            ops_done_count <= '0;
            cur_op         <= '0;
            wd_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_bus.op_valid) begin
                        cur_op   <= op_bus.op_in;
                        op_rdy_q <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (sel_rdy) begin
                        lin_trigger   <= (sel == SEL_LIN);
                        circ_trigger  <= (sel == SEL_CIRC);
                        dummy_trigger <= (sel == SEL_DUMMY);
                        state         <= TRIGGER;
                    end
                end
                TRIGGER: begin
                    lin_trigger   <= 1'b0;
                    circ_trigger  <= 1'b0;
                    dummy_trigger <= 1'b0;
                    wd_cnt        <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sel_done) begin
                        ops_done_count <= ops_done_count + CNT_WIDTH'(1);
                        op_rdy_q       <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end else if (wd_expired) begin
                        op_rdy_q <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    lin_trigger   <= 1'b0;
                    circ_trigger  <= 1'b0;
                    dummy_trigger <= 1'b0;
                    op_rdy_q      <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase

            // A watchdog expiry outranks a clear arriving in the same cycle.
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_op_handler_scheduler.sv
// Directed bench for op_handler_scheduler with a short watchdog and a 2-bit
// op counter so expiry and wrap-around are reached quickly.
module tb_op_handler_scheduler;
    import op_handler_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       lin_rdy, lin_done, circ_rdy, circ_done, dummy_rdy, dummy_done;
    logic       lin_trigger, circ_trigger, dummy_trigger;
    logic       clear_err, busy, timeout_err;
    logic [1:0] ops_done_count;
    op_st       cur_op;
    op_st       op_a;

    int n_vec = 0;
    int n_err = 0;

    wire [2:0] trig = {lin_trigger, circ_trigger, dummy_trigger};

    op_handler_scheduler_if bus ();

    op_handler_scheduler #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_bus         (bus),
        .cur_op         (cur_op),
        .lin_trigger    (lin_trigger),
        .lin_rdy        (lin_rdy),
        .lin_done       (lin_done),
        .circ_trigger   (circ_trigger),
        .circ_rdy       (circ_rdy),
        .circ_done      (circ_done),
        .dummy_trigger  (dummy_trigger),
        .dummy_rdy      (dummy_rdy),
        .dummy_done     (dummy_done),
        .clear_err      (clear_err),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .ops_done_count (ops_done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    function automatic op_st mk(input logic [7:0] c, input logic [15:0] x);
        op_st o;
        o.cmd  = c;
        o.x    = x;
        o.y    = x + 16'd3;
        o.feed = 16'h0100;
        return o;
    endfunction

    // Presents op for one cycle while IDLE; returns on the first WAIT_RDY negedge.
    task automatic accept(input op_st op);
        bus.op_in    = op;
        bus.op_valid = 1'b1;
        step;
        bus.op_valid = 1'b0;
    endtask

    // Dummy-routed op with stray lin/circ done pulses before the real done.
    task automatic run_dummy(input string tag, input op_st op, input logic [1:0] exp_cnt);
        accept(op);
        step;
        chk({tag, "_trig"}, 64'(trig), 64'(3'b001));
        step;
        lin_done  = 1'b1;
        circ_done = 1'b1;
        step;
        lin_done  = 1'b0;
        circ_done = 1'b0;
        chk({tag, "_ignore_spurious"}, 64'(busy), 64'd1);
        dummy_done = 1'b1;
        step;
        dummy_done = 1'b0;
        chk({tag, "_rdy"}, 64'(bus.op_rdy), 64'd1);
        chk({tag, "_cnt"}, 64'(ops_done_count), 64'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b1;
        bus.op_in = '0; bus.op_valid = 1'b0;
        lin_rdy = 1'b0; lin_done = 1'b0;
        circ_rdy = 1'b0; circ_done = 1'b0;
        dummy_rdy = 1'b0; dummy_done = 1'b0;
        clear_err = 1'b0;
        step;
        step;
        chk("rst_op_rdy", 64'(bus.op_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        chk("rst_cnt", 64'(ops_done_count), 64'd0);
        chk("rst_cur_op", 64'(cur_op), 64'd0);
        reset = 1'b0;

        // G01, lin ready, done 5 cycles after trigger
        lin_rdy = 1'b1;
        op_a = mk(CMD_G01, 16'h1234);
        accept(op_a);
        chk("g01_wait_rdy", 64'({bus.op_rdy, busy, trig}), 64'(5'b01000));
        chk("g01_cur_op", 64'(cur_op), 64'(op_a));
        step;
        chk("g01_trig", 64'(trig), 64'(3'b100));
        step;
        chk("g01_trig_off", 64'(trig), 64'd0);
        repeat (4) step;
        lin_done = 1'b1;
        chk("g01_rdy_before_done", 64'(bus.op_rdy), 64'd0);
        step;
        lin_done = 1'b0;
        chk("g01_rdy_after_done", 64'({bus.op_rdy, busy}), 64'(2'b10));
        chk("g01_cnt", 64'(ops_done_count), 64'd1);
        chk("g01_cur_op_hold", 64'(cur_op), 64'(op_a));

        // G02 with circ held not-ready for 10 cycles
        accept(mk(CMD_G02, 16'h0202));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("g02_stall_%0d", i), 64'({busy, trig}), 64'(4'b1000));
            if (i < 9) step;
        end
        circ_rdy = 1'b1;
        step;
        chk("g02_trig", 64'(trig), 64'(3'b010));
        step;
        chk("g02_trig_off", 64'(trig), 64'd0);
        circ_done = 1'b1;
        step;
        circ_done = 1'b0;
        chk("g02_rdy", 64'(bus.op_rdy), 64'd1);
        chk("g02_cnt", 64'(ops_done_count), 64'd2);
        chk("g02_no_err", 64'(timeout_err), 64'd0);

        // G90 and an undefined cmd both go to dummy; counter wraps 3 -> 0
        dummy_rdy = 1'b1;
        run_dummy("g90", mk(CMD_G90, 16'h0090), 2'd3);
        run_dummy("undef", mk(8'hAB, 16'h00AB), 2'd0);

        // G00 with no done: watchdog expires after 8 WAIT_DONE cycles
        accept(mk(CMD_G00, 16'h0000));
        step;
        chk("to_trig", 64'(trig), 64'(3'b100));
        repeat (8) step;
        chk("to_not_yet", 64'({busy, timeout_err}), 64'(2'b10));
        clear_err = 1'b1;
        step;
        chk("to_set_beats_clear", 64'(timeout_err), 64'd1);
        chk("to_idle", 64'({bus.op_rdy, busy}), 64'(2'b10));
        chk("to_cnt_same", 64'(ops_done_count), 64'd0);
        step;
        clear_err = 1'b0;
        chk("to_cleared", 64'(timeout_err), 64'd0);

        // Done on the 8th WAIT_DONE cycle wins over expiry
        accept(mk(CMD_G00, 16'h0008));
        step;
        chk("edge_trig", 64'(trig), 64'(3'b100));
        repeat (8) step;
        lin_done = 1'b1;
        step;
        lin_done = 1'b0;
        chk("edge_no_err", 64'(timeout_err), 64'd0);
        chk("edge_cnt", 64'(ops_done_count), 64'd1);
        chk("edge_rdy", 64'(bus.op_rdy), 64'd1);

        // Async reset while in WAIT_DONE
        accept(mk(CMD_G01, 16'h0055));
        step;
        step;
        reset = 1'b1;
        #1;
        chk("arst_state", 64'({bus.op_rdy, busy, trig}), 64'(5'b10000));
        chk("arst_cnt", 64'(ops_done_count), 64'd0);
        chk("arst_cur_op", 64'(cur_op), 64'd0);
        step;
        reset = 1'b0;
        accept(mk(CMD_G03, 16'h0303));
        step;
        chk("g03_trig", 64'(trig), 64'(3'b010));
        step;
        circ_done = 1'b1;
        step;
        circ_done = 1'b0;
        chk("g03_cnt", 64'(ops_done_count), 64'd1);
        chk("g03_rdy", 64'(bus.op_rdy), 64'd1);

        // Five back-to-back dummy ops with op_valid held high
        reset = 1'b1;
        step;
        reset = 1'b0;
        bus.op_in    = mk(CMD_G91, 16'h0091);
        bus.op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_rdy_%0d", i), 64'(bus.op_rdy), 64'd1);
            step;
            step;
            chk($sformatf("b2b_trig_%0d", i), 64'(trig), 64'(3'b001));
            step;
            dummy_done = 1'b1;
            step;
            dummy_done = 1'b0;
            if (i == 4) bus.op_valid = 1'b0;
            chk($sformatf("b2b_cnt_%0d", i), 64'(ops_done_count), 64'(exp_seq[i]));
        end
        step;
        chk("b2b_end_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/op_handler_scheduler.md
Name: op_handler_scheduler

Overview:
- Sequences execution of parsed opcodes through the opcode handlers (linear, circular, dummy).
- Accepts one Op_st at a time from the op source over a valid/rdy handshake and latches it.
- Routes the latched op to the handler selected by its cmd, issues a single-cycle trigger once that handler is ready, and waits for its done.
- Provides a watchdog timeout and a completed-op counter for the processor status path.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles in WAIT_DONE before a timeout is declared; 0 disables the watchdog.
- CNT_WIDTH, 16: width of ops_done_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- op_in  in  Op_st  opcode from source; sampled only on accept
- op_valid  in  1  op_in valid
- op_rdy  out  1  scheduler can accept an op
- cur_op  out  Op_st  latched op currently being executed
- lin_trigger  out  1  one-cycle start pulse to linear handler (G00/G01)
- lin_rdy  in  1  linear handler ready
- lin_done  in  1  linear handler done pulse
- circ_trigger  out  1  start pulse to circular handler (G02/G03)
- circ_rdy  in  1  circular handler ready
- circ_done  in  1  circular handler done pulse
- dummy_trigger  out  1  start pulse to dummy handler (G90/G91/any other cmd)
- dummy_rdy  in  1  dummy handler ready
- dummy_done  in  1  dummy handler done pulse
- clear_err  in  1  clears timeout_err
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag
- ops_done_count  out  CNT_WIDTH  completed ops, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - op_rdy=1, all triggers=0, busy=0, timeout_err=0, ops_done_count=0.
  - cur_op=all-zero, watchdog counter=0.
  - Reset mid-op abandons the op with no trigger glitch.
- Handler selection from cur_op.cmd (combinational decode of the latched op only, never of op_in):
  - G00/G01 -> lin
  - G02/G03 -> circ
  - everything else -> dummy
  - Unselected triggers are always 0; rdy/done inputs of unselected handlers are ignored.
- States:
  - IDLE:
    - op_rdy=1.
    - On op_valid=1: cur_op<=op_in, next state WAIT_RDY.
  - WAIT_RDY:
    - op_rdy=0.
    - When the selected rdy=1: next state TRIGGER. Otherwise stay, with no timeout.
  - TRIGGER:
    - Selected trigger=1 for exactly this one cycle.
    - Watchdog counter cleared.
    - Unconditional next state WAIT_DONE.
  - WAIT_DONE:
    - Trigger=0.
    - Selected done=1: ops_done_count+=1, next state IDLE.
    - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: timeout_err<=1, next state IDLE, count unchanged.
    - Else counter+=1.
- Latency:
  - Accept on cycle N -> trigger on N+2 at the earliest (selected rdy already high on N+1).
  - done on cycle M -> op_rdy=1 on M+1. Back-to-back accept possible on M+1.
- done is sampled only in WAIT_DONE. A done seen in TRIGGER or WAIT_RDY is ignored; handlers must assert done at least one cycle after trigger.
- Simultaneous done and watchdog expiry in the same cycle: done wins (counted, no error).
- timeout_err:
  - Set has priority over clear_err in the same cycle.
  - clear_err in any other cycle clears it.
  - It does not block scheduling.
- ops_done_count wraps from 2^CNT_WIDTH-1 to 0.
- cur_op holds its value after completion until the next accept.
- Watchdog counter width is clog2(TIMEOUT_CYCLES)+1.

Test Plan:
- Reset, then G01 op with lin_rdy=1; lin_done at 5 cycles after trigger:
  - lin_trigger high exactly 1 cycle at accept+2.
  - circ_trigger and dummy_trigger stay 0.
  - ops_done_count=1; op_rdy returns the cycle after done.
- G02 with circ_rdy=0 for 10 cycles, then 1:
  - Scheduler stays in WAIT_RDY with busy=1 and no trigger.
  - circ_trigger fires 1 cycle after circ_rdy rises.
  - No timeout_err.
- cmd G90 and an undefined cmd value:
  - Each routes to dummy_trigger.
  - Spurious lin_done/circ_done pulses during WAIT_DONE are ignored; only dummy_done completes.
- TIMEOUT_CYCLES=8, G00 with lin_done never asserted:
  - timeout_err=1 exactly 8 cycles into WAIT_DONE; next cycle is IDLE; count unchanged.
  - clear_err then gives timeout_err=0.
  - With TIMEOUT_CYCLES=8 and done arriving on the 8th cycle instead, the op completes and no error is raised.
- Async reset asserted during WAIT_DONE:
  - Immediate IDLE, triggers=0, count=0.
  - After release, a new G03 op executes normally.
- CNT_WIDTH=2, five back-to-back dummy ops with dummy_rdy=1 and done one cycle after trigger:
  - Count sequence 1,2,3,0,1.
  - op_valid held high is accepted on each IDLE cycle.
